// File: rtl/io_bus_master.sv
// Bus initiator for the memory-mapped IO window: a command FIFO feeds a single-transfer FSM.
// Optional write responses are enabled by defining IO_BUS_MASTER_WRITE_RSP_EN.
module io_bus_master #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          RD_LAT     = 1,
  parameter logic [31:0] ADDR_BASE  = 32'h7f50,
  parameter logic [31:0] ADDR_LAST  = 32'h7f60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_byteen,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  input  logic [31:0] bus_rdata
);

  localparam int PTR_W = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);

  typedef struct packed {
    logic        we;
    logic [29:0] word;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a >= ADDR_BASE) && (a <= ADDR_LAST);
  endfunction

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;
  logic [31:0]      head_addr;
  logic             head_legal;
  logic             head_skip;

  state_t           state;
  logic             we_r;
  logic [LAT_W-1:0] wait_cnt;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[1:0];

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && !empty;
  assign head       = fifo_mem[rd_ptr];
  assign head_addr  = {head.word, 2'b00};
  assign head_legal = addr_legal(head_addr);
  assign head_skip  = !head_legal || (head.we && (head.byteen == 4'b0000));

  // Command FIFO storage (payload only, never reset)
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{we: cmd_we, word: cmd_addr[31:2], wdata: cmd_wdata, byteen: cmd_byteen};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transfer FSM: one command in flight, all bus and response outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_byteen <= '0;
    end else begin
      bus_byteen <= '0;
      case (state)
        IDLE: begin
          if (!empty) begin
            if (head_skip) begin
`ifdef IO_BUS_MASTER_WRITE_RSP_EN
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= !head_legal;
`else
              if (!head.we) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
              end
`endif
            end else begin
              state      <= ISSUE;
              we_r       <= head.we;
              bus_addr   <= head_addr;
              bus_wdata  <= head.wdata;
              bus_byteen <= head.we ? head.byteen : 4'b0000;
            end
          end
        end
        ISSUE: begin
          if (we_r) begin
`ifdef IO_BUS_MASTER_WRITE_RSP_EN
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`else
            state <= IDLE;
`endif
          end else if (RD_LAT == 1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus_rdata;
            rsp_err   <= 1'b0;
          end else begin
            state    <= WAIT;
            wait_cnt <= LAT_W'(1);
          end
        end
        WAIT: begin
          if (wait_cnt == LAT_W'(RD_LAT - 1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus_rdata;
            rsp_err   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: RD_LAT=1 instance driven from a vector table,
// RD_LAT=3 instance for read latency and mid-read reset sequences.
module tb_io_bus_master;

`ifdef IO_BUS_MASTER_WRITE_RSP_EN
  localparam bit WRSP = 1'b1;
`else
  localparam bit WRSP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_byteen = '0;
  logic        rsp_ready = 1'b1;
  logic        cmd_valid1 = 1'b0, cmd_valid3 = 1'b0;
  logic        cmd_ready1, cmd_ready3, rsp_valid1, rsp_valid3, rsp_err1, rsp_err3;
  logic [31:0] rsp_rdata1, rsp_rdata3, bus_addr1, bus_addr3, bus_wdata1, bus_wdata3;
  logic [3:0]  bus_byteen1, bus_byteen3;
  logic [31:0] bus_rdata1, bus_rdata3, rd_const = '0;
  logic        use_map = 1'b0;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_rdata1 = use_map ? {16'hB000, bus_addr1[15:0]} : rd_const;
  assign bus_rdata3 = 32'hC0DE_0000 + 32'(cyc);

  io_bus_master #(.FIFO_DEPTH(4), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byteen(cmd_byteen),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
    .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_byteen(bus_byteen1), .bus_rdata(bus_rdata1));

  io_bus_master #(.FIFO_DEPTH(4), .RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byteen(cmd_byteen),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .bus_addr(bus_addr3), .bus_wdata(bus_wdata3), .bus_byteen(bus_byteen3), .bus_rdata(bus_rdata3));

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    logic        rsp;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  pulse_be;
    logic [31:0] baddr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rd,
                              input logic rsp, input int lat, input logic [31:0] rdata,
                              input logic err, input logic [3:0] pulse_be, input logic [31:0] baddr);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be; v.rd = rd;
    v.rsp = rsp; v.lat = lat; v.rdata = rdata; v.err = err; v.pulse_be = pulse_be; v.baddr = baddr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int n_rsp = 0, lat = 0, n_pulse = 0;
    logic [31:0] rdata = '0, wd = '0;
    logic err = 1'b0;
    logic [3:0] be = '0;
    rd_const = v.rd;
    chk({v.name, "_ready"}, cmd_ready1, 1);
    cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_byteen = v.be; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (bus_byteen1 != 4'b0000) begin
        n_pulse++; be = bus_byteen1; wd = bus_wdata1;
      end
      if (rsp_valid1) begin
        if (n_rsp == 0) begin
          lat = k; rdata = rsp_rdata1; err = rsp_err1;
        end
        n_rsp++;
      end
      @(negedge clk);
    end
    chk({v.name, "_rsp_count"}, n_rsp, v.rsp ? 1 : 0);
    if (v.rsp) begin
      chk({v.name, "_latency"}, lat, v.lat);
      chk({v.name, "_rdata"}, rdata, v.rdata);
      chk({v.name, "_err"}, err, v.err);
    end
    chk({v.name, "_byteen_pulses"}, n_pulse, (v.pulse_be != 0) ? 1 : 0);
    if (v.pulse_be != 0) begin
      chk({v.name, "_byteen"}, be, v.pulse_be);
      chk({v.name, "_wdata"}, wd, v.wdata);
    end
    chk({v.name, "_bus_addr"}, bus_addr1, v.baddr);
  endtask

  task automatic rd3(input logic [31:0] addr, input string name);
    logic seen = 1'b0, got = 1'b0, err = 1'b0;
    int c1 = 0, c_rsp = 0;
    logic [31:0] rd = '0;
    cmd_we = 1'b0; cmd_addr = addr; cmd_wdata = 32'h0; cmd_byteen = 4'hF; cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!seen && bus_addr3 == {addr[31:2], 2'b00}) begin
        seen = 1'b1; c1 = cyc;
      end
      if (!got && rsp_valid3) begin
        got = 1'b1; c_rsp = cyc; rd = rsp_rdata3; err = rsp_err3;
      end
      @(negedge clk);
    end
    chk({name, "_addr_seen"}, seen, 1);
    chk({name, "_rsp_seen"}, got, 1);
    chk({name, "_hold_to_rsp"}, c_rsp - c1, 3);
    chk({name, "_rdata"}, rd, 32'hC0DE_0000 + 32'(c1 + 2));
    chk({name, "_err"}, err, 0);
    chk({name, "_byteen"}, bus_byteen3, 0);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ready1"}, cmd_ready1, 1);
    chk({pfx, "_rsp_valid1"}, rsp_valid1, 0);
    chk({pfx, "_bus_addr1"}, bus_addr1, 0);
    chk({pfx, "_ready3"}, cmd_ready3, 1);
    chk({pfx, "_rsp_valid3"}, rsp_valid3, 0);
    chk({pfx, "_rsp_rdata3"}, rsp_rdata3, 0);
    chk({pfx, "_rsp_err3"}, rsp_err3, 0);
    chk({pfx, "_bus_addr3"}, bus_addr3, 0);
    chk({pfx, "_bus_wdata3"}, bus_wdata3, 0);
    chk({pfx, "_bus_byteen3"}, bus_byteen3, 0);
  endtask

  logic [31:0] fill_exp[5];
  int got;
  int waited;

  initial begin
    vecs[0]  = mk("rd_7f52",   0, 32'h7f52, 32'h0,         4'h0, 32'h1234_5678, 1,    3, 32'h1234_5678, 0, 4'h0, 32'h7f50);
    vecs[1]  = mk("wr_7f60",   1, 32'h7f60, 32'hA5A5_A5A5, 4'h3, 32'h0,         WRSP, 3, 32'h0,         0, 4'h3, 32'h7f60);
    vecs[2]  = mk("rd_8000",   0, 32'h8000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1,    2, 32'h0,         1, 4'h0, 32'h7f60);
    vecs[3]  = mk("rd_7f4c",   0, 32'h7f4c, 32'h0,         4'h0, 32'hDEAD_BEEF, 1,    2, 32'h0,         1, 4'h0, 32'h7f60);
    vecs[4]  = mk("rd_7f63",   0, 32'h7f63, 32'h0,         4'h0, 32'h0000_00FF, 1,    3, 32'h0000_00FF, 0, 4'h0, 32'h7f60);
    vecs[5]  = mk("wr_be0",    1, 32'h7f54, 32'h1111_1111, 4'h0, 32'h0,         WRSP, 2, 32'h0,         0, 4'h0, 32'h7f60);
    vecs[6]  = mk("wr_9000",   1, 32'h9000, 32'h2222_2222, 4'hF, 32'h0,         WRSP, 2, 32'h0,         1, 4'h0, 32'h7f60);
    vecs[7]  = mk("wr_7f57",   1, 32'h7f57, 32'hCAFE_F00D, 4'h8, 32'h0,         WRSP, 3, 32'h0,         0, 4'h8, 32'h7f54);
    vecs[8]  = mk("rd_7f5c",   0, 32'h7f5c, 32'h0,         4'h0, 32'h8765_4321, 1,    3, 32'h8765_4321, 0, 4'h0, 32'h7f5c);
    vecs[9]  = mk("rd_7f64",   0, 32'h7f64, 32'h0,         4'h0, 32'h8765_4321, 1,    2, 32'h0,         1, 4'h0, 32'h7f5c);
    vecs[10] = mk("rd_base",   0, 32'h7f50, 32'h0,         4'h0, 32'h0BAD_F00D, 1,    3, 32'h0BAD_F00D, 0, 4'h0, 32'h7f50);

    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // FIFO fill: first command parks in RESP, then four more fill the FIFO
    use_map = 1'b1;
    rsp_ready = 1'b0;
    fill_exp[0] = 32'hB000_7f50; fill_exp[1] = 32'hB000_7f54; fill_exp[2] = 32'hB000_7f58;
    fill_exp[3] = 32'hB000_7f5c; fill_exp[4] = 32'hB000_7f60;
    cmd_we = 1'b0; cmd_wdata = '0; cmd_byteen = '0;
    cmd_addr = 32'h7f50; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    waited = 0;
    while (!rsp_valid1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("fill_first_rsp", rsp_valid1, 1);
    cmd_addr = 32'h7f54; cmd_valid1 = 1'b1;
    @(negedge clk);
    cmd_addr = 32'h7f58;
    @(negedge clk);
    cmd_addr = 32'h7f5d;
    @(negedge clk);
    chk("fill_ready_before_4th", cmd_ready1, 1);
    cmd_addr = 32'h7f60;
    @(negedge clk);
    cmd_valid1 = 1'b0;
    chk("fill_ready_after_4th", cmd_ready1, 0);
    chk("fill_rsp_held", rsp_rdata1, fill_exp[0]);
    rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid1 && got < 5) begin
        chk($sformatf("fill_rsp%0d_rdata", got), rsp_rdata1, fill_exp[got]);
        got++;
      end
      @(negedge clk);
    end
    chk("fill_rsp_count", got, 5);
    chk("fill_ready_reasserted", cmd_ready1, 1);
    use_map = 1'b0;

    rd3(32'h7f54, "lat3_a");

    // Reset asserted while the RD_LAT=3 instance holds a read address
    cmd_we = 1'b0; cmd_addr = 32'h7f58; cmd_wdata = 32'h55AA_55AA; cmd_byteen = 4'h0; cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    waited = 0;
    while (bus_addr3 != 32'h7f58 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_read_issued", bus_addr3, 32'h7f58);
    chk("rst_wdata_loaded", bus_wdata3, 32'h55AA_55AA);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid3) got++;
      @(negedge clk);
    end
    chk("rst_no_stale_rsp", got, 0);
    rd3(32'h7f5c, "lat3_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
